// File: rtl/memory_arbiter_pkg.sv
// rtl/memory_arbiter_pkg.sv - shared encodings and defaults for the memory port arbiter
package memory_arbiter_pkg;

    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_ADDR_WIDTH   = 16;
    localparam int DEF_MEM_WIDTH    = 13;
    localparam int DEF_STARVE_LIMIT = 4;
    localparam int STARVE_W         = 4;

    typedef enum logic {
        ARB      = 1'b0,
        DEV_RESP = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DEV = 1'b1
    } owner_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// rtl/memory_arbiter_if.sv - CPU, device and memory_block signal bundle for the arbiter
interface memory_arbiter_if
    import memory_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  cpu_req;
    logic                  cpu_halted;
    logic [ADDR_WIDTH-1:0] cpu_read_address;
    logic                  cpu_write_enable;
    logic [ADDR_WIDTH-1:0] cpu_write_address;
    logic [DATA_WIDTH-1:0] cpu_data_in;
    logic                  cpu_wait;
    logic [DATA_WIDTH-1:0] cpu_data_out;

    logic                  dev_req;
    logic                  dev_write;
    logic [ADDR_WIDTH-1:0] dev_address;
    logic [DATA_WIDTH-1:0] dev_wdata;
    logic                  dev_ack;
    logic                  dev_rvalid;
    logic [DATA_WIDTH-1:0] dev_rdata;
    logic                  dev_err;

    logic [ADDR_WIDTH-1:0] mem_read_address;
    logic [ADDR_WIDTH-1:0] mem_write_address;
    logic                  mem_write_enable;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic [DATA_WIDTH-1:0] mem_data_out;

    modport slave (
        input  cpu_req, cpu_halted, cpu_read_address, cpu_write_enable,
               cpu_write_address, cpu_data_in,
               dev_req, dev_write, dev_address, dev_wdata, mem_data_out,
        output cpu_wait, cpu_data_out, dev_ack, dev_rvalid, dev_rdata, dev_err,
               mem_read_address, mem_write_address, mem_write_enable, mem_data_in
    );

    modport master (
        output cpu_req, cpu_halted, cpu_read_address, cpu_write_enable,
               cpu_write_address, cpu_data_in,
               dev_req, dev_write, dev_address, dev_wdata, mem_data_out,
        input  cpu_wait, cpu_data_out, dev_ack, dev_rvalid, dev_rdata, dev_err,
               mem_read_address, mem_write_address, mem_write_enable, mem_data_in
    );

endinterface

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - shares the single memory_block port between CPU and one device
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int MEM_WIDTH    = DEF_MEM_WIDTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clock,
    input  logic              reset,
    memory_arbiter_if.slave   bus
);

    arb_state_t              r_state;
    logic [STARVE_W-1:0]     r_starve;
    owner_t                  r_rd_owner;
    logic [DATA_WIDTH-1:0]   r_cpu_hold;
    logic                    r_dev_read;
    logic                    r_dev_err;

    logic                    w_in_range;
    logic                    w_starved;
    logic                    w_dev_grant;
    logic                    w_resp;
    logic                    w_rvalid;

    assign w_in_range  = (bus.dev_address[ADDR_WIDTH-1:MEM_WIDTH] == '0);
    assign w_starved   = (r_starve == STARVE_W'(STARVE_LIMIT));
    assign w_dev_grant = (r_state == ARB) && bus.dev_req &&
                         (!bus.cpu_req || bus.cpu_halted || w_starved);
    assign w_resp      = (r_state == DEV_RESP);
    assign w_rvalid    = w_resp && r_dev_read && !r_dev_err;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ARB;
            r_starve   <= '0;
            r_rd_owner <= OWN_CPU;
            r_cpu_hold <= '0;
            r_dev_read <= 1'b0;
            r_dev_err  <= 1'b0;
        end else begin
            r_rd_owner <= w_dev_grant ? OWN_DEV : OWN_CPU;
            // Keep the last CPU-owned read so a stalled CPU sees stable data.
            if (r_rd_owner == OWN_CPU)
                r_cpu_hold <= bus.mem_data_out;
            case (r_state)
                ARB: begin
                    if (w_dev_grant) begin
                        r_state    <= DEV_RESP;
                        r_starve   <= '0;
                        r_dev_read <= !bus.dev_write;
                        r_dev_err  <= !w_in_range;
                    end else if (!bus.dev_req) begin
                        r_starve <= '0;
                    end else if (!w_starved) begin
                        r_starve <= r_starve + STARVE_W'(1);
                    end
                end
                DEV_RESP: r_state <= ARB;
                default:  r_state <= ARB;
            endcase
        end
    end

    // Outputs are forced to zero while reset is held, whatever the inputs do.
    always_comb begin
        bus.cpu_wait          = 1'b0;
        bus.cpu_data_out      = '0;
        bus.dev_ack           = 1'b0;
        bus.dev_rvalid        = 1'b0;
        bus.dev_rdata         = '0;
        bus.dev_err           = 1'b0;
        bus.mem_read_address  = '0;
        bus.mem_write_address = '0;
        bus.mem_write_enable  = 1'b0;
        bus.mem_data_in       = '0;
        if (reset) begin
            bus.cpu_wait     = w_dev_grant && bus.cpu_req && !bus.cpu_halted;
            bus.cpu_data_out = (r_rd_owner == OWN_CPU) ? bus.mem_data_out : r_cpu_hold;
            bus.dev_ack      = w_resp;
            bus.dev_rvalid   = w_rvalid;
            bus.dev_rdata    = w_rvalid ? bus.mem_data_out : '0;
            bus.dev_err      = w_resp && r_dev_err;
            if (w_dev_grant) begin
                bus.mem_read_address  = bus.dev_address;
                bus.mem_write_address = bus.dev_address;
                bus.mem_write_enable  = bus.dev_write && w_in_range;
                bus.mem_data_in       = bus.dev_wdata;
            end else begin
                bus.mem_read_address  = bus.cpu_read_address;
                bus.mem_write_address = bus.cpu_write_address;
                bus.mem_write_enable  = bus.cpu_write_enable;
                bus.mem_data_in       = bus.cpu_data_in;
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - self-checking bench for memory_arbiter with a memory_block model
module tb_memory_arbiter;

    logic clk;
    logic rst_n;
    logic mem_init;

    memory_arbiter_if bus ();

    memory_arbiter dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        rvalid;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic        cpu_req;
        logic        cpu_halted;
        logic        cpu_we;
        logic        dev_req;
        logic        dev_write;
        logic [15:0] dev_addr;
        logic        exp_wait;
        logic        exp_grant;
        logic        exp_we;
    } vec_t;

    function automatic logic [15:0] pat(input logic [15:0] a);
        case (a)
            16'h0005: return 16'hAAAA;
            16'h0006: return 16'h6666;
            16'h0007: return 16'h7777;
            16'h0010: return 16'hBEEF;
            default:  return {a[7:0], a[7:0]};
        endcase
    endfunction

    logic [15:0] mem [0:8191];

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 8192; i++) mem[i] <= pat(16'(i));
            bus.mem_data_out <= '0;
        end else begin
            if (bus.mem_write_enable)
                mem[bus.mem_write_address[12:0]] <= bus.mem_data_in;
            bus.mem_data_out <= mem[bus.mem_read_address[12:0]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic wr, input logic [15:0] addr, input logic [15:0] rd);
        exp_t e;
        e.err    = (addr >= 16'h2000);
        e.rvalid = !wr && !e.err;
        e.rdata  = e.rvalid ? rd : 16'h0000;
        return e;
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.dev_ack) begin
                if (sb.size() == 0) begin
                    chk("unexpected dev_ack", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("dev_rvalid", 32'(bus.dev_rvalid), 32'(e.rvalid));
                    chk("dev_rdata",  32'(bus.dev_rdata),  32'(e.rdata));
                    chk("dev_err",    32'(bus.dev_err),    32'(e.err));
                end
            end
        end
    endtask

    task automatic clear_inputs();
        bus.cpu_req = 0; bus.cpu_halted = 0; bus.cpu_read_address = 0;
        bus.cpu_write_enable = 0; bus.cpu_write_address = 0; bus.cpu_data_in = 0;
        bus.dev_req = 0; bus.dev_write = 0; bus.dev_address = 0; bus.dev_wdata = 0;
    endtask

    task automatic dev_idle();
        @(negedge clk);
        bus.dev_req = 0;
        @(posedge clk);
    endtask

    task automatic dev_txn(input string name, input logic wr, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [15:0] rd_exp,
                           input int ack_exp, input logic [15:0] wait_exp);
        int          ack;
        logic [15:0] wmask;
        exp_t        e;
        @(negedge clk);
        bus.dev_req = 1; bus.dev_write = wr; bus.dev_address = addr; bus.dev_wdata = wdata;
        e = mk_exp(wr, addr, rd_exp);
        sb.push_back(e);
        ack   = -1;
        wmask = '0;
        for (int n = 0; n < 12 && ack < 0; n++) begin
            #1;
            if (bus.cpu_wait) begin
                wmask[n] = 1'b1;
                chk({name, " stall mem addr"}, 32'(bus.mem_write_address), 32'(addr));
                chk({name, " stall mem we"}, 32'(bus.mem_write_enable), 32'(wr && !e.err));
            end
            @(posedge clk);
            #1;
            if (bus.dev_ack) ack = n + 1;
            else @(negedge clk);
        end
        chk({name, " ack cycle"}, 32'(ack), 32'(ack_exp));
        chk({name, " wait cycles"}, 32'(wmask), 32'(wait_exp));
    endtask

    vec_t vecs[7];

    initial begin
        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        vecs[0] = '{1,0,1, 0,0,16'h0000, 0,0,1};
        vecs[1] = '{1,0,0, 1,0,16'h0040, 0,0,0};
        vecs[2] = '{0,0,0, 1,0,16'h0040, 0,1,0};
        vecs[3] = '{1,1,0, 1,1,16'h0041, 0,1,1};
        vecs[4] = '{1,1,1, 0,0,16'h0000, 0,0,1};
        vecs[5] = '{0,0,0, 1,1,16'h8000, 0,1,0};
        vecs[6] = '{0,0,0, 0,0,16'h0000, 0,0,0};

        clear_inputs();
        rst_n    = 0;
        mem_init = 0;
        repeat (3) @(posedge clk);
        mem_init = 1;
        @(negedge clk);
        rst_n = 1;

        // Reset mid-run: outputs must go to zero and stay there after release.
        bus.cpu_req = 1; bus.cpu_read_address = 16'h0005;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("rst cpu_data_out", 32'(bus.cpu_data_out), 32'h0);
        chk("rst mem_read_address", 32'(bus.mem_read_address), 32'h0);
        chk("rst dev_ack", 32'(bus.dev_ack), 32'h0);
        clear_inputs();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        @(negedge clk);
        chk("post-rst cpu_data_out", 32'(bus.cpu_data_out), 32'h0);
        chk("post-rst outputs", 32'({bus.cpu_wait, bus.dev_ack, bus.dev_rvalid, bus.dev_err,
                                     bus.mem_write_enable}), 32'h0);

        // Single-cycle grant/mux decisions from an idle ARB state.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.cpu_req = vecs[i].cpu_req; bus.cpu_halted = vecs[i].cpu_halted;
            bus.cpu_write_enable = vecs[i].cpu_we;
            bus.cpu_read_address = 16'h0100; bus.cpu_write_address = 16'h0101;
            bus.cpu_data_in = 16'hC0DE;
            bus.dev_req = vecs[i].dev_req; bus.dev_write = vecs[i].dev_write;
            bus.dev_address = vecs[i].dev_addr; bus.dev_wdata = 16'hD00D;
            if (vecs[i].exp_grant)
                sb.push_back(mk_exp(vecs[i].dev_write, vecs[i].dev_addr, pat(vecs[i].dev_addr)));
            #1;
            chk($sformatf("vec%0d cpu_wait", i), 32'(bus.cpu_wait), 32'(vecs[i].exp_wait));
            chk($sformatf("vec%0d mem_read_address", i), 32'(bus.mem_read_address),
                32'(vecs[i].exp_grant ? vecs[i].dev_addr : 16'h0100));
            chk($sformatf("vec%0d mem_write_enable", i), 32'(bus.mem_write_enable),
                32'(vecs[i].exp_we));
            if (vecs[i].exp_we)
                chk($sformatf("vec%0d mem_data_in", i), 32'(bus.mem_data_in),
                    32'(vecs[i].exp_grant ? 16'hD00D : 16'hC0DE));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d dev_ack", i), 32'(bus.dev_ack), 32'(vecs[i].exp_grant));
            @(negedge clk);
            clear_inputs();
            @(posedge clk);
        end

        // Idle CPU: immediate grant, ack next cycle.
        dev_txn("t2 read 0x10", 0, 16'h0010, 16'h0, 16'hBEEF, 1, 16'h0000);
        dev_idle();

        // CPU busy every cycle: forced grant after the starvation limit.
        @(negedge clk);
        bus.cpu_req = 1; bus.cpu_write_enable = 1; bus.cpu_write_address = 16'h0030;
        bus.cpu_data_in = 16'h5555; bus.cpu_read_address = 16'h0031;
        dev_txn("t3 write 0x20", 1, 16'h0020, 16'h1234, 16'h0, 5, 16'h0010);
        @(negedge clk);
        clear_inputs();
        @(posedge clk);
        #1;
        chk("t3 mem[0x20]", 32'(mem[16'h0020]), 32'h1234);
        chk("t3 mem[0x30]", 32'(mem[16'h0030]), 32'h5555);

        // Halted CPU: back-to-back reads, DEV_RESP blocks the regrant.
        @(negedge clk);
        bus.cpu_halted = 1; bus.cpu_req = 1;
        dev_txn("t4 read 0x0", 0, 16'h0000, 16'h0, pat(16'h0000), 1, 16'h0000);
        dev_txn("t4 read 0x1", 0, 16'h0001, 16'h0, pat(16'h0001), 2, 16'h0000);
        dev_idle();
        @(negedge clk);
        clear_inputs();

        // Out-of-range read and write.
        dev_txn("t5 read 0x2000", 0, 16'h2000, 16'h0, 16'h0, 1, 16'h0000);
        dev_idle();
        dev_txn("t5 write 0xFFFF", 1, 16'hFFFF, 16'h9999, 16'h0, 1, 16'h0000);
        dev_idle();
        chk("t5 mem[0x1FFF] untouched", 32'(mem[16'h1FFF]), 32'(pat(16'h1FFF)));

        // CPU read data held stable across a forced device read.
        @(negedge clk);
        bus.cpu_req = 1; bus.cpu_read_address = 16'h0005;
        bus.dev_req = 1; bus.dev_write = 0; bus.dev_address = 16'h0006;
        sb.push_back(mk_exp(0, 16'h0006, 16'h6666));
        for (int c = 0; c <= 6; c++) begin
            #1;
            chk($sformatf("t6 c%0d cpu_wait", c), 32'(bus.cpu_wait), 32'(c == 4));
            if (c >= 1 && c <= 5)
                chk($sformatf("t6 c%0d cpu_data_out", c), 32'(bus.cpu_data_out), 32'hAAAA);
            if (c == 5) begin
                bus.cpu_read_address = 16'h0007;
                bus.dev_req = 0;
            end
            if (c == 6)
                chk("t6 fresh cpu_data_out", 32'(bus.cpu_data_out), 32'h7777);
            @(negedge clk);
        end
        clear_inputs();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("scoreboard drained", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
